fcl_cntrl_gen: RTL and testbench
================================

FCL_CNTRL_GEN -- requirements
Module: fcl_cntrl_gen

Interface
- REQ-001: Parameter SRAM_ADDR_W, default 3: SRAM address width.
- REQ-002: Parameter WORDS_PER_NEURON, default 5: SRAM words written, then read, per neuron.
- REQ-003: Parameter NUM_NEURONS, default 120: neurons per layer pass.
- REQ-004: Parameter NEURON_CNT_W, default 7: neuron index width.
- REQ-005: Port fcl_ctrl_clk, input, 1: single clock; all state updates on its rising edge.
- REQ-006: Port fcl_ctrl_rst, input, 1: reset, synchronous and active-high.
- REQ-007: Port fcl1_wake_i, input, 1: start a layer pass; honoured only in IDLE.
- REQ-008: Port fcl1_restart_i, input, 1: abort or finish, then return to IDLE.
- REQ-009: Port wr_data_valid_i, input, 1: write data present this cycle.
- REQ-010: Port rd_ready_i, input, 1: consumer accepts read data this cycle.
- REQ-011: Port fcl_cntrl_top_sram_wr_en_o, output, 1: SRAM write strobe.
- REQ-012: Port fcl_cntrl_top_sram_rd_en_o, output, 1: SRAM read strobe.
- REQ-013: Port fcl_cntrl_top_sram_addr_o, output, SRAM_ADDR_W: SRAM address, registered.
- REQ-014: Port neuron_idx_o, output, NEURON_CNT_W: current neuron index, registered.
- REQ-015: Port neuron_done_o, output, 1: one-cycle pulse on the final read beat of a neuron.
- REQ-016: Port layer_done_o, output, 1: high while in DONE.
- REQ-017: Port busy_o, output, 1: high in WR or RD.

Function
- REQ-018: The FSM SHALL have states IDLE, WR, RD and DONE.
- REQ-019: In IDLE, fcl1_wake_i=1 SHALL move the FSM to WR on the next edge; addr=0 and idx=0.
- REQ-020: Write strobe SHALL equal (state==WR) & wr_data_valid_i, combinationally; read strobe SHALL equal (state==RD) & rd_ready_i.
- REQ-021: Each strobe beat SHALL increment addr by 1; with no strobe, addr SHALL hold (stall).
- REQ-022: A write beat at addr==WORDS_PER_NEURON-1 SHALL wrap addr to 0 and move the FSM to RD.
- REQ-023: A read beat at addr==WORDS_PER_NEURON-1 SHALL wrap addr to 0 and assert neuron_done_o in that same cycle.
- REQ-024: After that beat, idx==NUM_NEURONS-1 SHALL move the FSM to DONE; otherwise idx SHALL increment and the FSM SHALL move to WR.
- REQ-025: DONE SHALL hold with both strobes at 0 until fcl1_restart_i=1.
- REQ-026: fcl1_restart_i=1 in any state SHALL force both strobes to 0 that cycle and go to IDLE next edge with addr=0 and idx=0. Restart SHALL take priority over wake and over strobe beats.
- REQ-027: fcl1_wake_i outside IDLE SHALL be ignored.
- REQ-028: The block SHALL require 1 <= WORDS_PER_NEURON <= 2^SRAM_ADDR_W and 1 <= NUM_NEURONS <= 2^NEURON_CNT_W. A violation SHALL raise an elaboration error.
- REQ-029: WORDS_PER_NEURON=1 SHALL give one write beat then one read beat per neuron.

Reset
- REQ-030: While fcl_ctrl_rst=1, state=IDLE, addr=0 and idx=0. All outputs SHALL be 0, including the strobes, regardless of inputs.
- REQ-031: Reset mid-pass SHALL discard progress; the next pass SHALL start from neuron 0, address 0.

Configuration
- REQ-032: With macro FCL_CTRL_STALL_CNT_EN defined, the block SHALL add output stall_cnt_o[15:0].
  - Counts cycles in WR with wr_data_valid_i=0 plus cycles in RD with rd_ready_i=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset, by restart, and by an accepted wake.
- REQ-033: Without FCL_CTRL_STALL_CNT_EN, stall_cnt_o and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification (WORDS_PER_NEURON=5, NUM_NEURONS=3)
- REQ-034: Wake with valid/ready held 1.
  - Expect addr 0..4 with wr_en, then 0..4 with rd_en, for idx 0, 1, 2.
  - neuron_done_o pulses 3 times; layer_done_o=1 after 30 active cycles.
- REQ-035: Drop wr_data_valid_i for 2 cycles at addr 2 of neuron 1: wr_en=0 and addr holds at 2 for 2 cycles. With the macro, stall_cnt_o=2.
- REQ-036: Assert restart during RD of neuron 1 at addr 3.
  - Next cycle: IDLE, addr=0, idx=0, strobes 0.
  - A new wake restarts at neuron 0.
- REQ-037: Assert wake and restart together in IDLE: stays IDLE, busy_o=0.
- REQ-038: Assert fcl_ctrl_rst mid-WR at addr 4: all outputs 0 next edge; wake afterwards begins at addr 0.
- REQ-039: In DONE, toggle wake without restart: stays DONE, layer_done_o=1, no strobes.

Source files
------------

// File: rtl/fcl_cntrl_gen.sv
// SRAM write-then-read sequencer for one fully-connected layer pass, one neuron at a time.
// Optional stall counter output enabled by defining FCL_CTRL_STALL_CNT_EN.
module fcl_cntrl_gen #(
  parameter int SRAM_ADDR_W      = 3,
  parameter int WORDS_PER_NEURON = 5,
  parameter int NUM_NEURONS      = 120,
  parameter int NEURON_CNT_W     = 7
) (
  input  logic                    fcl_ctrl_clk,
  input  logic                    fcl_ctrl_rst,
  input  logic                    fcl1_wake_i,
  input  logic                    fcl1_restart_i,
  input  logic                    wr_data_valid_i,
  input  logic                    rd_ready_i,
  output logic                    fcl_cntrl_top_sram_wr_en_o,
  output logic                    fcl_cntrl_top_sram_rd_en_o,
  output logic [SRAM_ADDR_W-1:0]  fcl_cntrl_top_sram_addr_o,
  output logic [NEURON_CNT_W-1:0] neuron_idx_o,
  output logic                    neuron_done_o,
  output logic                    layer_done_o,
  output logic                    busy_o
`ifdef FCL_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cnt_o
`endif
);

  if (WORDS_PER_NEURON < 1 || WORDS_PER_NEURON > (1 << SRAM_ADDR_W) ||
      NUM_NEURONS < 1 || NUM_NEURONS > (1 << NEURON_CNT_W)) begin : g_bad_cfg
    $error("fcl_cntrl_gen: WORDS_PER_NEURON or NUM_NEURONS out of range");
  end

  localparam logic [SRAM_ADDR_W-1:0]  ADDR_LAST = SRAM_ADDR_W'(WORDS_PER_NEURON - 1);
  localparam logic [NEURON_CNT_W-1:0] IDX_LAST  = NEURON_CNT_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

  state_t                  state;
  logic [SRAM_ADDR_W-1:0]  addr;
  logic [NEURON_CNT_W-1:0] idx;
  logic                    kill, wr_beat, rd_beat, last_word;

  // Reset and restart both squash strobes in the same cycle they are seen.
  assign kill      = fcl_ctrl_rst | fcl1_restart_i;
  assign wr_beat   = (state == S_WR) & wr_data_valid_i & ~kill;
  assign rd_beat   = (state == S_RD) & rd_ready_i & ~kill;
  assign last_word = (addr == ADDR_LAST);

  always_ff @(posedge fcl_ctrl_clk) begin
    if (fcl_ctrl_rst || fcl1_restart_i) begin
      state <= S_IDLE;
      addr  <= '0;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: if (fcl1_wake_i) begin
          state <= S_WR;
          addr  <= '0;
          idx   <= '0;
        end
        S_WR: if (wr_beat) begin
          if (last_word) begin
            addr  <= '0;
            state <= S_RD;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        S_RD: if (rd_beat) begin
          if (last_word) begin
            addr <= '0;
            if (idx == IDX_LAST) begin
              state <= S_DONE;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_WR;
            end
          end else begin
            addr <= addr + 1'b1;
          end
        end
        default: state <= S_DONE;
      endcase
    end
  end

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign fcl_cntrl_top_sram_wr_en_o = wr_beat;
  assign fcl_cntrl_top_sram_rd_en_o = rd_beat;
  assign fcl_cntrl_top_sram_addr_o  = fcl_ctrl_rst ? '0 : addr;
  assign neuron_idx_o               = fcl_ctrl_rst ? '0 : idx;
  assign neuron_done_o              = rd_beat & last_word;
  assign layer_done_o               = (state == S_DONE) & ~fcl_ctrl_rst;
  assign busy_o                     = ((state == S_WR) | (state == S_RD)) & ~fcl_ctrl_rst;

`ifdef FCL_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic        stall_cyc;

  assign stall_cyc = ((state == S_WR) & ~wr_data_valid_i) | ((state == S_RD) & ~rd_ready_i);

  always_ff @(posedge fcl_ctrl_clk) begin
    if (fcl_ctrl_rst || fcl1_restart_i || (state == S_IDLE && fcl1_wake_i))
      stall_cnt <= '0;
    else if (stall_cyc && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign stall_cnt_o = fcl_ctrl_rst ? '0 : stall_cnt;
`endif

endmodule

// File: tb/tb_fcl_cntrl_gen.sv
// Directed vector bench for fcl_cntrl_gen with WORDS_PER_NEURON=5, NUM_NEURONS=3.
module tb_fcl_cntrl_gen;
  localparam int AW = 3;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          rst, wake, restart, valid, ready;
  logic          wr_en, rd_en, ndone, ldone, busy;
  logic [AW-1:0] addr;
  logic [IW-1:0] idx;
`ifdef FCL_CTRL_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fcl_cntrl_gen #(.SRAM_ADDR_W(AW), .WORDS_PER_NEURON(5), .NUM_NEURONS(3), .NEURON_CNT_W(IW)) dut (
    .fcl_ctrl_clk               (clk),
    .fcl_ctrl_rst               (rst),
    .fcl1_wake_i                (wake),
    .fcl1_restart_i             (restart),
    .wr_data_valid_i            (valid),
    .rd_ready_i                 (ready),
    .fcl_cntrl_top_sram_wr_en_o (wr_en),
    .fcl_cntrl_top_sram_rd_en_o (rd_en),
    .fcl_cntrl_top_sram_addr_o  (addr),
    .neuron_idx_o               (idx),
    .neuron_done_o              (ndone),
    .layer_done_o               (ldone),
    .busy_o                     (busy)
`ifdef FCL_CTRL_STALL_CNT_EN
    ,
    .stall_cnt_o                (stall_cnt)
`endif
  );

  typedef struct {
    logic       rst, wake, restart, valid, ready;
    logic       wr, rd;
    int         addr, idx;
    logic       nd, ld, busy;
    int         stall;
    string      name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string name, logic r, logic w, logic rs, logic v, logic rd_rdy,
                              logic e_wr, logic e_rd, int e_addr, int e_idx,
                              logic e_nd, logic e_ld, logic e_busy, int e_stall = 0);
    vec_t t;
    t.name = name; t.rst = r; t.wake = w; t.restart = rs; t.valid = v; t.ready = rd_rdy;
    t.wr = e_wr; t.rd = e_rd; t.addr = e_addr; t.idx = e_idx;
    t.nd = e_nd; t.ld = e_ld; t.busy = e_busy; t.stall = e_stall;
    return t;
  endfunction

  // Drive one cycle's inputs, check outputs within that cycle, then advance one edge.
  task automatic step(input vec_t t);
    rst = t.rst; wake = t.wake; restart = t.restart; valid = t.valid; ready = t.ready;
    #1;
    checks++;
    if (wr_en !== t.wr || rd_en !== t.rd || int'(addr) != t.addr || int'(idx) != t.idx ||
        ndone !== t.nd || ldone !== t.ld || busy !== t.busy) begin
      errors++;
      $display("FAIL %s: got wr=%b rd=%b addr=%0d idx=%0d nd=%b ld=%b busy=%b, want wr=%b rd=%b addr=%0d idx=%0d nd=%b ld=%b busy=%b",
               t.name, wr_en, rd_en, addr, idx, ndone, ldone, busy,
               t.wr, t.rd, t.addr, t.idx, t.nd, t.ld, t.busy);
    end
`ifdef FCL_CTRL_STALL_CNT_EN
    checks++;
    if (int'(stall_cnt) != t.stall) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d want %0d", t.name, stall_cnt, t.stall);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wake = 1'b0; restart = 1'b0; valid = 1'b0; ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset, one full pass with no stalls, DONE behaviour, restart back to IDLE.
    tbl.push_back(mk("reset",     1, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("idle_wake", 0, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 3; n++) begin
      for (int a = 0; a < 5; a++) tbl.push_back(mk("pass_wr", 0, 0, 0, 1, 1, 1, 0, a, n, 0, 0, 1));
      for (int a = 0; a < 5; a++) tbl.push_back(mk("pass_rd", 0, 0, 0, 1, 1, 0, 1, a, n, a == 4, 0, 1));
    end
    tbl.push_back(mk("done",       0, 0, 0, 1, 1,  0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk("done_wake1", 0, 1, 0, 1, 1,  0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk("done_wake0", 0, 0, 0, 1, 1,  0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk("done_wake2", 0, 1, 0, 1, 1,  0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk("done_rst",   0, 0, 1, 1, 1,  0, 0, 0, 2, 0, 1, 0));
    tbl.push_back(mk("idle_again", 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("wake_rs",    0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("wake_rs_nx", 0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i]);

    // Write stall at neuron 1 addr 2, then restart mid-read at addr 3.
    step(mk("s_wake", 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int a = 0; a < 5; a++) step(mk("s_n0_wr", 0, 0, 0, 1, 1, 1, 0, a, 0, 0, 0, 1));
    for (int a = 0; a < 5; a++) step(mk("s_n0_rd", 0, 0, 0, 1, 1, 0, 1, a, 0, a == 4, 0, 1));
    step(mk("s_n1_wr0",   0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 1, 0));
    step(mk("s_n1_wr1",   0, 0, 0, 1, 1, 1, 0, 1, 1, 0, 0, 1, 0));
    step(mk("s_stall_a",  0, 0, 0, 0, 1, 0, 0, 2, 1, 0, 0, 1, 0));
    step(mk("s_stall_b",  0, 0, 0, 0, 1, 0, 0, 2, 1, 0, 0, 1, 1));
    step(mk("s_resume",   0, 0, 0, 1, 1, 1, 0, 2, 1, 0, 0, 1, 2));
    step(mk("s_n1_wr3",   0, 0, 0, 1, 1, 1, 0, 3, 1, 0, 0, 1, 2));
    step(mk("s_n1_wr4",   0, 0, 0, 1, 1, 1, 0, 4, 1, 0, 0, 1, 2));
    for (int a = 0; a < 3; a++) step(mk("s_n1_rd", 0, 0, 0, 1, 1, 0, 1, a, 1, 0, 0, 1, 2));
    step(mk("s_restart",  0, 0, 1, 1, 1, 0, 0, 3, 1, 0, 0, 1, 2));
    step(mk("s_rs_idle",  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    // New pass begins at neuron 0; reset mid-write at addr 4.
    step(mk("r_wake",     0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int a = 0; a < 4; a++) step(mk("r_wr", 0, 0, 0, 1, 1, 1, 0, a, 0, 0, 0, 1));
    step(mk("r_reset",    1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    step(mk("r_post",     0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    step(mk("r_wake2",    0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    step(mk("r_wr0",      0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1));
    step(mk("r_wr1",      0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
